// File: rtl/traffic_pkg.sv
// Shared constants and types for the traffic_light intersection and its
// upstream farm-road sensor conditioner.
package traffic_pkg;

    localparam int unsigned LIGHT_W = 3;

    localparam logic [LIGHT_W-1:0] LIGHT_GREEN  = 3'b001;
    localparam logic [LIGHT_W-1:0] LIGHT_YELLOW = 3'b010;
    localparam logic [LIGHT_W-1:0] LIGHT_RED    = 3'b100;

    typedef enum logic [1:0] {
        ABSENT   = 2'd0,
        QUAL_ON  = 2'd1,
        PRESENT  = 2'd2,
        QUAL_OFF = 2'd3
    } deb_state_e;

    // Any encoding other than the exact green pattern is not-green.
    function automatic logic is_green(input logic [LIGHT_W-1:0] light);
        return (light == LIGHT_GREEN);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchroniser with asynchronous active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/farm_sensor_conditioner.sv
// Synchronises and debounces the farm-road loop, latches each arrival until
// the farm road is served green, counts arrivals and flags a stuck loop.
module farm_sensor_conditioner
    import traffic_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned STUCK_CYCLES    = 1000,
    parameter int unsigned CNT_W           = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               raw_detect,
    input  logic [LIGHT_W-1:0] light_farm,
    output logic               sensor,
    output logic [CNT_W-1:0]   car_count,
    output logic               fault
);

    localparam int unsigned QUAL_W = 8;
    localparam int unsigned STK_W  = $clog2(STUCK_CYCLES + 1);

    localparam logic [QUAL_W-1:0] QUAL_LAST = QUAL_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [STK_W-1:0]  STK_MAX   = STK_W'(STUCK_CYCLES);

    logic              sync_det;
    deb_state_e        state_q, state_d;
    logic [QUAL_W-1:0] qual_q, qual_d;
    logic [STK_W-1:0]  stuck_q, stuck_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              latch_q, latch_d;
    logic              fault_q, fault_d;
    logic              sensor_q, sensor_d;
    logic              arrival;
    logic              engaged;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (raw_detect),
        .q_o   (sync_det)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ABSENT;
            qual_q   <= '0;
            stuck_q  <= '0;
            count_q  <= '0;
            latch_q  <= 1'b0;
            fault_q  <= 1'b0;
            sensor_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            qual_q   <= qual_d;
            stuck_q  <= stuck_d;
            count_q  <= count_d;
            latch_q  <= latch_d;
            fault_q  <= fault_d;
            sensor_q <= sensor_d;
        end
    end

    // Debounce FSM: qual_q counts consecutive synchronised samples at the new level.
    always_comb begin
        state_d = state_q;
        qual_d  = qual_q;
        arrival = 1'b0;
        case (state_q)
            ABSENT: begin
                if (sync_det) begin
                    state_d = QUAL_ON;
                    qual_d  = QUAL_W'(1);
                end
            end
            QUAL_ON: begin
                if (!sync_det) begin
                    state_d = ABSENT;
                    qual_d  = '0;
                end else if (qual_q >= QUAL_LAST) begin
                    state_d = PRESENT;
                    qual_d  = '0;
                    arrival = 1'b1;
                end else begin
                    qual_d = qual_q + QUAL_W'(1);
                end
            end
            PRESENT: begin
                if (!sync_det) begin
                    state_d = QUAL_OFF;
                    qual_d  = QUAL_W'(1);
                end
            end
            QUAL_OFF: begin
                if (sync_det) begin
                    state_d = PRESENT;
                    qual_d  = '0;
                end else if (qual_q >= QUAL_LAST) begin
                    state_d = ABSENT;
                    qual_d  = '0;
                end else begin
                    qual_d = qual_q + QUAL_W'(1);
                end
            end
            default: begin
                state_d = ABSENT;
                qual_d  = '0;
            end
        endcase
    end

    // Request latch, saturating arrival count and stuck-loop watchdog.
    always_comb begin
        engaged  = (state_q == PRESENT) || (state_q == QUAL_OFF);
        latch_d  = latch_q;
        count_d  = count_q;
        stuck_d  = '0;
        if (arrival) begin
            latch_d = 1'b1;
        end else if (is_green(light_farm)) begin
            latch_d = 1'b0;
        end
        if (arrival && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
        if (engaged) begin
            stuck_d = (stuck_q == STK_MAX) ? stuck_q : stuck_q + STK_W'(1);
        end
        fault_d  = (stuck_d == STK_MAX);
        sensor_d = latch_q | engaged | fault_q;
    end

    assign sensor    = sensor_q;
    assign car_count = count_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_farm_sensor_conditioner.sv
// Randomised scoreboard bench for farm_sensor_conditioner against a
// sample-window reference model.
module tb_farm_sensor_conditioner;
    import traffic_pkg::*;

    localparam int unsigned D = 4;
    localparam int unsigned S = 1000;
    localparam int unsigned W = 8;
    localparam int unsigned CMAX = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         raw_detect;
    logic [2:0]   light_farm;
    logic         sensor;
    logic [W-1:0] car_count;
    logic         fault;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    farm_sensor_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .STUCK_CYCLES    (S),
        .CNT_W           (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw_detect (raw_detect),
        .light_farm (light_farm),
        .sensor     (sensor),
        .car_count  (car_count),
        .fault      (fault)
    );

    typedef struct packed {
        logic         sensor;
        logic [W-1:0] cnt;
        logic         fault;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the debounced level follows the raw input once the D samples
    // that have cleared the synchroniser all agree; otherwise it holds.
    logic hist [D+2];
    logic m_deb, m_latch, m_fault;
    int   m_cnt, m_stuck;

    always @(posedge clk) begin : model
        exp_t e;
        logic all1, all0, old_deb, arr;
        if (!rst_n) begin
            for (int i = 0; i < D + 2; i++) hist[i] = 1'b0;
            m_deb = 1'b0; m_latch = 1'b0; m_fault = 1'b0;
            m_cnt = 0; m_stuck = 0;
            e = '0;
        end else begin
            for (int i = D + 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = raw_detect;
            all1 = 1'b1; all0 = 1'b1;
            for (int i = 2; i <= D + 1; i++) begin
                if (hist[i]) all0 = 1'b0;
                else         all1 = 1'b0;
            end
            e.sensor = m_latch | m_deb | m_fault;
            old_deb = m_deb;
            if (all1)      m_deb = 1'b1;
            else if (all0) m_deb = 1'b0;
            arr = !old_deb && m_deb;
            if (arr) m_latch = 1'b1;
            else if (light_farm == 3'b001) m_latch = 1'b0;
            if (arr && m_cnt < CMAX) m_cnt++;
            m_stuck = old_deb ? ((m_stuck < S) ? m_stuck + 1 : S) : 0;
            m_fault = (m_stuck == S);
            e.cnt   = W'(m_cnt);
            e.fault = m_fault;
        end
        exp_q.push_back(e);
    end

    // Monitor: one expected response per clock edge.
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            n_checks++;
            if ({sensor, car_count, fault} !== {e.sensor, e.cnt, e.fault}) begin
                n_fail++;
                $display("FAIL outputs: got sensor=%b count=%0d fault=%b expected sensor=%b count=%0d fault=%b at %0t",
                         sensor, car_count, fault, e.sensor, e.cnt, e.fault, $time);
            end
        end
    end

    function automatic logic [2:0] rand_light();
        return 3'($urandom_range(0, 7));
    endfunction

    task automatic step(input logic r, input logic [2:0] l);
        @(negedge clk);
        raw_detect = r;
        light_farm = l;
    endtask

    task automatic hold(input logic r, input logic [2:0] l, input int n);
        for (int i = 0; i < n; i++) step(r, l);
    endtask

    initial begin : driver
        int  lat;
        logic got;
        rst_n      = 1'b0;
        raw_detect = 1'b0;
        light_farm = LIGHT_RED;

        // Reset held with a toggling loop input
        for (int i = 0; i < 20; i++) step(1'($urandom_range(0, 1)), rand_light());
        chk("reset_sensor", int'(sensor), 0);
        chk("reset_count", int'(car_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        hold(1'b0, LIGHT_RED, 6);

        // Clean arrival latency
        step(1'b1, LIGHT_RED);
        lat = 0; got = 1'b0;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(posedge clk);
            #2;
            if (sensor) begin got = 1'b1; lat = i; end
        end
        chk("arrival_latency", lat, D + 3);
        hold(1'b1, LIGHT_RED, 44);
        chk("arrival_count", int'(car_count), 1);

        // Car leaves unserved: latch keeps request up until green
        hold(1'b0, LIGHT_RED, 12);
        chk("latched_sensor", int'(sensor), 1);
        step(1'b0, LIGHT_GREEN);
        hold(1'b0, LIGHT_RED, 3);
        chk("cleared_sensor", int'(sensor), 0);

        // Glitch shorter than the debounce window
        hold(1'b1, LIGHT_RED, 2);
        hold(1'b0, LIGHT_RED, 12);
        chk("glitch_count", int'(car_count), 1);
        chk("glitch_sensor", int'(sensor), 0);

        // Green coincides with the arrival edge: set wins
        hold(1'b1, LIGHT_RED, 5);
        step(1'b1, LIGHT_GREEN);
        hold(1'b0, LIGHT_RED, 20);
        chk("set_wins_sensor", int'(sensor), 1);
        hold(1'b0, LIGHT_GREEN, 2);
        hold(1'b0, LIGHT_RED, 3);

        // Stuck detector
        hold(1'b1, LIGHT_RED, 5);
        for (int i = 0; i < S + 100; i++) step(1'b1, ($urandom_range(0, 1) != 0) ? LIGHT_GREEN : LIGHT_RED);
        hold(1'b1, LIGHT_GREEN, 2);
        chk("stuck_fault", int'(fault), 1);
        chk("stuck_sensor_green", int'(sensor), 1);
        hold(1'b0, LIGHT_RED, 15);
        chk("stuck_release", int'(fault), 0);
        hold(1'b0, LIGHT_GREEN, 2);

        // Count saturation
        for (int i = 0; i < 260; i++) begin
            hold(1'b1, rand_light(), 8);
            hold(1'b0, rand_light(), 8);
        end
        chk("count_saturated", int'(car_count), int'(CMAX));

        // Reset while qualifying
        hold(1'b0, LIGHT_RED, 10);
        hold(1'b1, LIGHT_RED, 3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_count", int'(car_count), 0);
        chk("midreset_sensor", int'(sensor), 0);
        chk("midreset_fault", int'(fault), 0);
        hold(1'b1, LIGHT_RED, 3);
        @(negedge clk);
        rst_n = 1'b1;
        raw_detect = 1'b0;
        hold(1'b0, LIGHT_RED, 5);
        hold(1'b1, LIGHT_RED, 12);
        chk("post_reset_count", int'(car_count), 1);

        // Random runs with occasional resets and illegal light codes
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            hold(1'($urandom_range(0, 1)), rand_light(), $urandom_range(1, 10));
        end

        hold(1'b0, LIGHT_RED, 5);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/farm_sensor_conditioner.md
Name: farm_sensor_conditioner

Overview:
Upstream stage of traffic_light. It turns the raw, asynchronous farm-road vehicle-loop input into the clean, registered `sensor` request that traffic_light consumes. It synchronises and debounces the loop and latches each detected vehicle until the farm road has been served green. It also counts vehicles and flags a stuck detector.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronised cycles needed to accept a level change (range 1..255).
STUCK_CYCLES, 1000, continuous debounced-present cycles before fault is raised.
CNT_W, 8, width of car_count.

Ports:
clk  input  1  system clock, same clock as traffic_light.
rst_n  input  1  asynchronous active-low reset.
raw_detect  input  1  raw loop detector; asynchronous; may glitch.
light_farm  input  3  farm light state, fed back from traffic_light.
sensor  output  1  registered vehicle request to traffic_light.
car_count  output  CNT_W  saturating count of accepted vehicle arrivals.
fault  output  1  stuck-detector flag.

Behaviour:
- Reset (async assert, sync release): sensor=0, car_count=0, fault=0, latch=0, FSM=ABSENT, sync flops=0, counters=0.
- Synchroniser: 2-FF on raw_detect gives sync_det. No other logic touches raw_detect.
- Debounce FSM states:
  - ABSENT to QUAL_ON: when sync_det=1.
  - QUAL_ON to PRESENT: when qual counter reaches DEBOUNCE_CYCLES with sync_det held 1.
  - QUAL_ON back to ABSENT: any 0 in the qualifying window; the counter clears.
  - PRESENT to QUAL_OFF: when sync_det=0.
  - QUAL_OFF to ABSENT: after DEBOUNCE_CYCLES consecutive 0s.
  - QUAL_OFF back to PRESENT: any 1 in the window; the counter clears.
- Arrival event: the single cycle of the QUAL_ON to PRESENT transition.
- Latency: sensor rises exactly DEBOUNCE_CYCLES+3 rising edges after raw_detect becomes stably high. This is 2 sync + DEBOUNCE_CYCLES qualify + 1 output register; 7 edges at default.
- Pulses shorter than DEBOUNCE_CYCLES synchronised cycles produce no event and no output change.
- Request latch:
  - Set on arrival event.
  - Cleared on any cycle where light_farm == LIGHT_GREEN.
  - Simultaneous set and clear: set wins.
- sensor (registered) = latch OR (FSM in PRESENT or QUAL_OFF) OR fault.
  - A car that leaves before being served keeps sensor=1 until farm green.
  - A car still present during green keeps sensor=1.
- car_count: +1 per arrival event; saturates at 2^CNT_W−1 with no wrap.
- Stuck detection:
  - Stuck counter increments each cycle in PRESENT/QUAL_OFF and clears in ABSENT.
  - When it reaches STUCK_CYCLES, fault=1.
  - fault is sticky until FSM returns to ABSENT (debounced release) or reset. fault=1 forces sensor=1 (fail-safe: farm keeps being served).
  - Stuck counter saturates at STUCK_CYCLES.
- light_farm values other than the three legal encodings are treated as not-green.
- Reset mid-operation: all state returns to reset values immediately. A latched request is lost; the loop must re-qualify after release.

Decomposition:
- Shared package traffic_pkg:
  - LIGHT_GREEN=3'b001, LIGHT_YELLOW=3'b010, LIGHT_RED=3'b100; traffic_light uses the same constants.
  - Debounce state typedef {ABSENT, QUAL_ON, PRESENT, QUAL_OFF}.
- One sub-module: sync_2ff (1-bit two-flop synchroniser, async active-low reset). It is reused elsewhere in the codebase.

Test Plan:
- Reset values: rst_n=0 for 20 clocks with raw_detect toggling → sensor=0, car_count=0, fault=0 throughout.
- Clean arrival: raw_detect 0→1 held 50 clocks, light_farm=RED → sensor rises at edge 7 after the change; car_count=1.
- Glitch rejection: raw_detect=1 for 2 clocks, then 0 → sensor stays 0; car_count stays 0.
- Latch and clear:
  - Car present 10 clocks then leaves, light_farm=RED → sensor stays 1.
  - Then light_farm=GREEN for 1 cycle → sensor=0 one edge later.
  - Simultaneous arrival event and GREEN → latch stays 1.
- Stuck detector:
  - raw_detect held 1 → fault=1 once 1000 present cycles are reached; sensor=1 even during GREEN.
  - raw_detect→0 → fault=0 after debounce.
- Saturation and reset mid-op:
  - 260 clean arrivals (CNT_W=8) → car_count=255.
  - Assert rst_n=0 mid-QUAL_ON → all outputs 0 immediately; after release, the next arrival yields car_count=1.
